// File: rtl/cv32e40x_board_ctrl.sv
// Board-level bring-up controller for the cv32e40x test harness.
// Synchronises and debounces push-buttons, sequences the core reset and
// fetch enable, latches the test outcome and shows it on LEDs. The exit
// value is shown NUM_LED-4 bits at a time; btn[1] steps through the pages.
// btn[0] is a board-level reset request that restarts the harness without
// touching the selected page.
// The sequencer state is held in state_q (type state_e) so checkers can bind
// to it directly.
module cv32e40x_board_ctrl #(
  parameter int NUM_BTN            = 7,
  parameter int NUM_LED            = 8,
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int FETCH_DELAY_CYCLES = 8,
  parameter int BLINK_DIV_LOG2     = 23
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_LED-1:0] led_o,
  output logic               core_rst_no,
  output logic               fetch_enable_o,
  input  logic               tests_passed_i,
  input  logic               tests_failed_i,
  input  logic               exit_valid_i,
  input  logic [31:0]        exit_value_i
);

  // Exit-value paging geometry; bits above 31 of the last page read as zero.
  localparam int VAL_W     = NUM_LED - 4;
  localparam int NUM_PAGES = (32 + VAL_W - 1) / VAL_W;
  localparam int EXT_W     = NUM_PAGES * VAL_W;
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  // Counter widths.
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int SEQ_MAX = (RST_HOLD_CYCLES > FETCH_DELAY_CYCLES) ? RST_HOLD_CYCLES
                                                                  : FETCH_DELAY_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [1:0]         btn_db_q;
  logic [DB_W-1:0]    db_cnt_q [2];

  // Two-flop synchroniser on every button bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Buttons above btn[1] have no function yet; they are synchronised so a
  // future user gets a clean signal, and parked here until then.
  generate
    if (NUM_BTN > 2) begin : g_spare_btn
      logic [NUM_BTN-3:0] unused_btn_sync;
      assign unused_btn_sync = sync2_q[NUM_BTN-1:2];
    end
  endgenerate

  // Debounce btn[1:0]: accept a new level only after it has differed from the
  // debounced value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db_q    <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == btn_db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reset / fetch sequencer and outcome latch
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             exit_q, exit_d;
  logic [31:0]      exit_val_q, exit_val_d;

  // Sequencer state, counter and outcome latch registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_HOLD;
      seq_cnt_q      <= '0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      exit_q         <= 1'b0;
      exit_val_q     <= '0;
      core_rst_no    <= 1'b0;
      fetch_enable_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_cnt_q      <= seq_cnt_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      exit_q         <= exit_d;
      exit_val_q     <= exit_val_d;
      core_rst_no    <= (state_d != ST_HOLD);
      fetch_enable_o <= (state_d == ST_RUN) || (state_d == ST_DONE);
    end
  end

  // Next-state logic; a debounced btn[0] overrides everything, including a
  // harness flag arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    seq_cnt_d  = seq_cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    exit_d     = exit_q;
    exit_val_d = exit_val_q;

    if (btn_db_q[0]) begin
      state_d    = ST_HOLD;
      seq_cnt_d  = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      exit_d     = 1'b0;
      exit_val_d = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (seq_cnt_q == SEQ_W'(RST_HOLD_CYCLES - 1)) begin
            state_d   = ST_RELEASE;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
          end
        end
        ST_RELEASE: begin
          if (seq_cnt_q == SEQ_W'(FETCH_DELAY_CYCLES - 1)) begin
            state_d   = ST_RUN;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
          end
        end
        ST_RUN, ST_DONE: begin
          // Flags accumulate; the exit value is frozen once first captured.
          pass_d = pass_q | tests_passed_i;
          fail_d = fail_q | tests_failed_i;
          exit_d = exit_q | exit_valid_i;
          if (exit_valid_i && !exit_q) begin
            exit_val_d = exit_value_i;
          end
          if (tests_passed_i || tests_failed_i || exit_valid_i) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d   = ST_HOLD;
          seq_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Heartbeat, paging and LEDs
  // ---------------------------------------------------------------------------
  logic [BLINK_DIV_LOG2-1:0] blink_cnt_q;
  logic [PAGE_W-1:0]         page_q;
  logic                      btn1_prev_q;
  logic [EXT_W-1:0]          exit_val_ext;
  logic [VAL_W-1:0]          page_bits;
  logic                      led_hb;

  // Free-running heartbeat divider.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_DIV_LOG2'(1);
    end
  end

  // Page select steps on each debounced btn[1] press; only rst_ni clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      page_q      <= '0;
      btn1_prev_q <= 1'b0;
    end else begin
      btn1_prev_q <= btn_db_q[1];
      if (btn_db_q[1] && !btn1_prev_q) begin
        page_q <= (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
      end
    end
  end

  assign exit_val_ext = EXT_W'(exit_val_q);

  // Select the exit-value slice for the current page.
  always_comb begin
    page_bits = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page_q == PAGE_W'(p)) begin
        page_bits = exit_val_ext[p*VAL_W +: VAL_W];
      end
    end
  end

  // Activity LED: blinks while running, solid once the harness has reported.
  always_comb begin
    led_hb = 1'b0;
    unique case (state_q)
      ST_RUN:  led_hb = blink_cnt_q[BLINK_DIV_LOG2-1];
      ST_DONE: led_hb = 1'b1;
      default: led_hb = 1'b0;
    endcase
  end

  // LED register, one cycle behind its sources.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_o <= '0;
    end else begin
      led_o <= {page_bits, exit_q, led_hb, fail_q, pass_q};
    end
  end

endmodule

// File: tb/tb_cv32e40x_board_ctrl.sv
// Testbench for cv32e40x_board_ctrl: directed stimulus, a cycle model built
// from the behavioural rules, a per-cycle compare, and literal spot checks.
module tb_cv32e40x_board_ctrl;

  localparam int D = 4;   // debounce cycles
  localparam int R = 16;  // reset hold cycles
  localparam int F = 8;   // fetch delay cycles
  localparam int B = 5;   // heartbeat divider log2

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [6:0]  btn_i = '0;
  logic        tests_passed_i = 1'b0;
  logic        tests_failed_i = 1'b0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic [7:0]  led_o;
  logic        core_rst_no;
  logic        fetch_enable_o;

  always #5 clk = ~clk;

  cv32e40x_board_ctrl #(
    .NUM_BTN(7), .NUM_LED(8), .DEBOUNCE_CYCLES(D), .RST_HOLD_CYCLES(R),
    .FETCH_DELAY_CYCLES(F), .BLINK_DIV_LOG2(B)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .btn_i(btn_i), .led_o(led_o),
    .core_rst_no(core_rst_no), .fetch_enable_o(fetch_enable_o),
    .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  localparam int PH_HOLD = 0, PH_REL = 1, PH_RUN = 2, PH_DONE = 3;
  int          m_phase = PH_HOLD;
  int          m_quiet = 0;      // consecutive HOLD cycles without reset request
  int          m_rel = 0;        // cycles spent in RELEASE
  int          m_page = 0;
  int          m_cyc = 0;        // cycles since reset
  logic [1:0]  m_db = '0;
  logic        m_db1_prev = 1'b0;
  logic        m_pass = 1'b0, m_fail = 1'b0, m_ev = 1'b0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_led = '0;
  logic        m_core = 1'b0, m_fetch = 1'b0;
  logic [1:0]  m_hist[$];        // raw btn[1:0] samples, newest first
  logic [1:0]  new_db;
  logic        flip;
  logic        hb;
  logic [31:0] nib;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase = PH_HOLD; m_quiet = 0; m_rel = 0; m_page = 0; m_cyc = 0;
      m_db = '0; m_db1_prev = 1'b0;
      m_pass = 1'b0; m_fail = 1'b0; m_ev = 1'b0; m_val = '0;
      m_led = '0; m_core = 1'b0; m_fetch = 1'b0;
      m_hist.delete();
    end else begin
      // LEDs show the state as it stood before this edge.
      hb = (m_phase == PH_RUN) ? (((m_cyc >> (B - 1)) & 1) != 0) : (m_phase == PH_DONE);
      nib = (m_val >> (4 * m_page)) & 32'hF;
      m_led = {nib[3:0], m_ev, hb, m_fail, m_pass};

      if (m_db[1] && !m_db1_prev) m_page = (m_page + 1) % 8;
      m_db1_prev = m_db[1];

      if (m_db[0]) begin
        m_phase = PH_HOLD; m_quiet = 0;
        m_pass = 1'b0; m_fail = 1'b0; m_ev = 1'b0; m_val = '0;
      end else if (m_phase == PH_HOLD) begin
        m_quiet++;
        if (m_quiet == R) begin m_phase = PH_REL; m_rel = 0; end
      end else if (m_phase == PH_REL) begin
        m_rel++;
        if (m_rel == F) m_phase = PH_RUN;
      end else begin
        if (exit_valid_i && !m_ev) m_val = exit_value_i;
        m_pass = m_pass | tests_passed_i;
        m_fail = m_fail | tests_failed_i;
        m_ev   = m_ev | exit_valid_i;
        if (tests_passed_i || tests_failed_i || exit_valid_i) m_phase = PH_DONE;
      end

      // A debounced bit flips once the synchronised input (raw input two
      // cycles back) has disagreed with it for the last D cycles.
      new_db = m_db;
      for (int i = 0; i < 2; i++) begin
        flip = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (m_hist.size() > 1 + j) begin
            if (m_hist[1 + j][i] == m_db[i]) flip = 1'b0;
          end else if (m_db[i] == 1'b0) begin
            flip = 1'b0;
          end
        end
        if (flip) new_db[i] = ~m_db[i];
      end
      m_db = new_db;
      m_hist.push_front(btn_i[1:0]);
      if (m_hist.size() > D + 2) void'(m_hist.pop_back());

      m_core  = (m_phase != PH_HOLD);
      m_fetch = (m_phase == PH_RUN) || (m_phase == PH_DONE);
      m_cyc++;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    n_vec += 3;
    if (led_o !== m_led) begin
      n_err++;
      $display("FAIL cyc_led t=%0t got=%h exp=%h", $time, led_o, m_led);
    end
    if (core_rst_no !== m_core) begin
      n_err++;
      $display("FAIL cyc_core_rst_no t=%0t got=%b exp=%b", $time, core_rst_no, m_core);
    end
    if (fetch_enable_o !== m_fetch) begin
      n_err++;
      $display("FAIL cyc_fetch_enable t=%0t got=%b exp=%b", $time, fetch_enable_o, m_fetch);
    end
  end

  // Literal spot check: DUT against a hand value, and the model against it.
  task automatic check_lit(input string name, input logic [31:0] got,
                           input logic [31:0] mdl, input logic [31:0] lit);
    n_vec += 2;
    if (got !== lit) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, lit);
    end
    if (mdl !== lit) begin
      n_err++;
      $display("FAIL %s_model got=%h exp=%h", name, mdl, lit);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic p, input logic f, input logic ev, input logic [31:0] v);
    tests_passed_i = p; tests_failed_i = f; exit_valid_i = ev; exit_value_i = v;
    tick(1);
    tests_passed_i = 1'b0; tests_failed_i = 1'b0; exit_valid_i = 1'b0;
    tick(2);
  endtask

  task automatic press_page(input int n);
    for (int i = 0; i < n; i++) begin
      btn_i[1] = 1'b1; tick(10);
      btn_i[1] = 1'b0; tick(10);
    end
  endtask

  // 20-cycle btn[0] press; optionally a failure flag lands in the cycle the
  // debounced button first reads high.
  task automatic button_reset(input logic inj_fail);
    @(posedge clk); #2;
    btn_i[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #2;
      if (k == 6 && inj_fail) tests_failed_i = 1'b1;
      if (k == 7) tests_failed_i = 1'b0;
      if (k == 20) btn_i[0] = 1'b0;
      @(negedge clk);
      if (k == 6)  check_lit("brst_core_k6", 32'(core_rst_no), 32'(m_core), 32'h1);
      if (k == 7)  check_lit("brst_core_k7", 32'(core_rst_no), 32'(m_core), 32'h0);
      if (k == 8)  check_lit("brst_led_k8", 32'(led_o), 32'(m_led), 32'h00);
      if (k == 41) check_lit("brst_core_k41", 32'(core_rst_no), 32'(m_core), 32'h0);
      if (k == 42) check_lit("brst_core_k42", 32'(core_rst_no), 32'(m_core), 32'h1);
      if (k == 49) check_lit("brst_fetch_k49", 32'(fetch_enable_o), 32'(m_fetch), 32'h0);
      if (k == 50) check_lit("brst_fetch_k50", 32'(fetch_enable_o), 32'(m_fetch), 32'h1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk); @(negedge clk);
    check_lit("reset_led", 32'(led_o), 32'(m_led), 32'h00);
    check_lit("reset_core", 32'(core_rst_no), 32'(m_core), 32'h0);
    check_lit("reset_fetch", 32'(fetch_enable_o), 32'(m_fetch), 32'h0);
    #2 rst_ni = 1'b1;

    // Power-on sequencing, edges counted from rst_ni release.
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 15) check_lit("por_core_e15", 32'(core_rst_no), 32'(m_core), 32'h0);
      if (n == 16) check_lit("por_core_e16", 32'(core_rst_no), 32'(m_core), 32'h1);
      if (n == 23) check_lit("por_fetch_e23", 32'(fetch_enable_o), 32'(m_fetch), 32'h0);
      if (n == 23) check_lit("por_led_e23", 32'(led_o), 32'(m_led), 32'h00);
      if (n == 24) check_lit("por_fetch_e24", 32'(fetch_enable_o), 32'(m_fetch), 32'h1);
    end

    // Short btn[0] glitch and spare-button noise must not disturb RUN.
    tick(1);
    btn_i[6:2] = 5'($urandom_range(1, 31));
    btn_i[0] = 1'b1; tick(3);
    btn_i[0] = 1'b0; tick(10);
    btn_i[6:2] = '0;
    @(negedge clk);
    check_lit("glitch_core", 32'(core_rst_no), 32'(m_core), 32'h1);
    check_lit("glitch_fetch", 32'(fetch_enable_o), 32'(m_fetch), 32'h1);

    // Exit + pass together, then a later exit value that must be ignored.
    tick(1);
    pulse(1'b1, 1'b0, 1'b1, 32'h0000_00A5);
    @(negedge clk); check_lit("done_led_5d", 32'(led_o), 32'(m_led), 32'h5D);
    tick(1);
    pulse(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk); check_lit("exit_frozen", 32'(led_o), 32'(m_led), 32'h5D);
    tick(1);
    pulse(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check_lit("fail_or_in", 32'(led_o), 32'(m_led), 32'h5F);

    // Debounced button reset clears the outcome and re-sequences the core.
    button_reset(1'b0);

    tick(1);
    pulse(1'b0, 1'b0, 1'b1, 32'h1234_ABCD);
    @(negedge clk); check_lit("page0_dc", 32'(led_o), 32'(m_led), 32'hDC);
    tick(1);
    press_page(3);
    @(negedge clk); check_lit("page3_ac", 32'(led_o), 32'(m_led), 32'hAC);
    tick(1);
    press_page(5);
    @(negedge clk); check_lit("page_wrap", 32'(led_o), 32'(m_led), 32'hDC);

    // Reset request and a failure flag in the same cycle: reset wins.
    button_reset(1'b1);

    // Page survives button reset but not rst_ni.
    tick(1);
    press_page(1);
    pulse(1'b0, 1'b0, 1'b1, 32'h0000_00F3);
    @(negedge clk); check_lit("page1_fc", 32'(led_o), 32'(m_led), 32'hFC);
    @(posedge clk); #2 rst_ni = 1'b0;
    @(negedge clk);
    check_lit("async_led", 32'(led_o), 32'(m_led), 32'h00);
    check_lit("async_core", 32'(core_rst_no), 32'(m_core), 32'h0);
    check_lit("async_fetch", 32'(fetch_enable_o), 32'(m_fetch), 32'h0);
    tick(2);
    rst_ni = 1'b1;
    tick(24);
    @(negedge clk); check_lit("rerun_fetch", 32'(fetch_enable_o), 32'(m_fetch), 32'h1);
    tick(40);
    pulse(1'b0, 1'b0, 1'b1, 32'h0000_00F3);
    @(negedge clk); check_lit("page_reset_3c", 32'(led_o), 32'(m_led), 32'h3C);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
